// File: rtl/ravenna_adc_seq.sv
// Multi-channel SAR ADC scan sequencer: walks the enabled channels, averages
// 2^avg conversions per channel and publishes per-channel results with flags.
module ravenna_adc_seq #(
  parameter int NCH  = 4,
  parameter int RES  = 10,
  parameter int AVGW = 2,
  parameter int TMO  = 1023,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_en,
  input  logic               cfg_cont,
  input  logic [NCH-1:0]     cfg_mask,
  input  logic [AVGW-1:0]    cfg_avg,
  input  logic               start,
  output logic               adc_start,
  output logic [CHW-1:0]     adc_sel,
  input  logic               adc_done,
  input  logic [RES-1:0]     adc_data,
  output logic [NCH*RES-1:0] res_data,
  output logic [NCH-1:0]     res_valid,
  input  logic [NCH-1:0]     res_rd,
  output logic [NCH-1:0]     overrun,
  output logic               busy,
  output logic               scan_done,
  output logic               tmo_err
);

  localparam int MAXE = (1 << AVGW) - 1;
  localparam int ACCW = RES + MAXE;
  localparam int CNTW = MAXE + 1;
  localparam int TMOW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, CONV, WAIT, STORE} state_t;

  state_t            state, state_nxt;
  logic [NCH-1:0]    mask_q;
  logic [AVGW-1:0]   avg_q;
  logic [CHW-1:0]    ch;
  logic [ACCW-1:0]   acc;
  logic [CNTW-1:0]   cnt;
  logic [TMOW-1:0]   tmo_cnt;
  logic              abort;

  logic [CHW:0]      first;
  logic [CHW:0]      nxt;
  logic [CNTW-1:0]   cnt_inc;
  logic              last_smp;
  logic              tmo_hit;
  logic              stop;
  logic              relatch;
  logic              go;

  // MSB of the result flags "found"; lower bits hold the channel index.
  function automatic logic [CHW:0] lowest(input logic [NCH-1:0] m);
    logic [CHW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (m[k]) r = {1'b1, CHW'(k)};
    return r;
  endfunction

  function automatic logic [CHW:0] next_above(input logic [NCH-1:0] m,
                                              input logic [CHW-1:0] c);
    logic [CHW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (m[k] && (k > int'(c))) r = {1'b1, CHW'(k)};
    return r;
  endfunction

  function automatic logic [RES-1:0] avg_shift(input logic [ACCW-1:0] a,
                                               input logic [AVGW-1:0] e);
    logic [ACCW-1:0] s;
    s = a >> e;
    return s[RES-1:0];
  endfunction

  assign first    = lowest(cfg_mask);
  assign nxt      = next_above(mask_q, ch);
  assign cnt_inc  = cnt + 1'b1;
  assign last_smp = (cnt_inc == (CNTW'(1) << avg_q));
  assign tmo_hit  = (tmo_cnt == TMOW'(TMO - 1));
  assign stop     = abort | ~cfg_en;
  assign relatch  = cfg_cont & cfg_en & first[CHW];
  assign go       = start & cfg_en & first[CHW];
  assign adc_sel  = ch;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    scan_done = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (go) state_nxt = CONV;
      CONV: begin
        adc_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (adc_done) begin
          if (stop)          state_nxt = IDLE;
          else if (last_smp) state_nxt = STORE;
          else               state_nxt = CONV;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      STORE: begin
        if (!cfg_en) begin
          state_nxt = IDLE;
        end else if (nxt[CHW]) begin
          state_nxt = CONV;
        end else begin
          scan_done = 1'b1;
          state_nxt = relatch ? CONV : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      avg_q     <= '0;
      ch        <= '0;
      acc       <= '0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      abort     <= 1'b0;
      res_data  <= '0;
      res_valid <= '0;
      overrun   <= '0;
      tmo_err   <= 1'b0;
    end else begin
      // Reads clear in any state; a store in the same cycle overrides below.
      res_valid <= res_valid & ~res_rd;
      case (state)
        IDLE: begin
          if (go) begin
            mask_q <= cfg_mask;
            avg_q  <= cfg_avg;
            ch     <= first[CHW-1:0];
            acc    <= '0;
            cnt    <= '0;
            abort  <= 1'b0;
          end
        end
        CONV: begin
          tmo_cnt <= '0;
          if (!cfg_en) abort <= 1'b1;
        end
        WAIT: begin
          if (adc_done) begin
            acc <= acc + ACCW'(adc_data);
            cnt <= cnt_inc;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) tmo_err <= 1'b1;
            if (!cfg_en) abort <= 1'b1;
          end
        end
        STORE: begin
          acc <= '0;
          cnt <= '0;
          if (cfg_en) begin
            res_data[int'(ch)*RES +: RES] <= avg_shift(acc, avg_q);
            res_valid[ch] <= 1'b1;
            if (res_valid[ch] && !res_rd[ch]) overrun[ch] <= 1'b1;
            if (nxt[CHW]) begin
              ch <= nxt[CHW-1:0];
            end else if (relatch) begin
              mask_q <= cfg_mask;
              avg_q  <= cfg_avg;
              ch     <= first[CHW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
